// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl -- bit-serial ALU sequencer.
//
// Accepts two WIDTH-bit operands and a 4-bit control word {ainvert, binvert, aluop[1:0]}.
// It then processes one bit per clock, LSB first, through a 1-bit ALU slice. The carry is
// held in a register between bits. When all bits are done it returns the full result and
// the zero/carry/overflow flags with a one-cycle done pulse.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   start      in   1      operation request, sampled only while idle
//   a, b       in   WIDTH  operands, latched on accept
//   alu_ctl    in   4      {ainvert, binvert, aluop[1:0]}, latched on accept
//   busy       out  1      high from accept until the result is delivered
//   done       out  1      one-cycle pulse, result/flags updated
//   result     out  WIDTH  registered result, held until the next done
//   zero       out  1      result == 0
//   carry_out  out  1      carry out of MSB (aluop=10 only)
//   overflow   out  1      signed overflow (aluop=10 only)
module alu_serial_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_t;

  // Control state (reset)
  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;

  // Serial datapath state (not reset; fully loaded on accept)
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic             cin_msb_q, cin_msb_d;
  logic             sum_msb_q, sum_msb_d;

  // 1-bit slice signals for the bit currently at the LSB of the shifters
  logic             ai, bi, sum_bit, slice_bit, maj_bit;
  logic             less, ovf_raw;
  logic [WIDTH-1:0] final_res;

  always_comb begin
    ai      = a_sh_q[0] ^ ctl_q[3];
    bi      = b_sh_q[0] ^ ctl_q[2];
    sum_bit = ai ^ bi ^ carry_q;
    maj_bit = (ai & bi) | (ai & carry_q) | (bi & carry_q);
    unique case (ctl_q[1:0])
      2'b00:   slice_bit = ai & bi;
      2'b01:   slice_bit = ai | bi;
      2'b10:   slice_bit = sum_bit;
      default: slice_bit = 1'b0;  // SLT: sum kept only for the MSB
    endcase

    // After the last bit carry_q holds the carry out of the MSB.
    ovf_raw   = cin_msb_q ^ carry_q;
    less      = sum_msb_q ^ ovf_raw;
    final_res = (ctl_q[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, less} : res_sh_q;
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    ctl_d       = ctl_q;
    res_sh_d    = res_sh_q;
    count_d     = count_q;
    carry_d     = carry_q;
    cin_msb_d   = cin_msb_q;
    sum_msb_d   = sum_msb_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          ctl_d   = alu_ctl;
          count_d = '0;
          carry_d = alu_ctl[2];  // binvert doubles as the +1 of two's complement
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
        res_sh_d = {slice_bit, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = maj_bit;
        count_d  = count_q + 1'b1;
        if (count_q == LAST_BIT) begin
          cin_msb_d = carry_q;
          sum_msb_d = sum_bit;
          state_d   = S_FINISH;
        end
      end
      S_FINISH: begin
        result_d    = final_res;
        zero_d      = (final_res == '0);
        carry_out_d = (ctl_q[1:0] == 2'b10) ? carry_q : 1'b0;
        overflow_d  = (ctl_q[1:0] == 2'b10) ? ovf_raw : 1'b0;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    a_sh_q    <= a_sh_d;
    b_sh_q    <= b_sh_d;
    ctl_q     <= ctl_d;
    res_sh_q  <= res_sh_d;
    count_q   <= count_d;
    carry_q   <= carry_d;
    cin_msb_q <= cin_msb_d;
    sum_msb_q <= sum_msb_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl -- directed, table-driven bench for alu_serial_ctrl (WIDTH=16).
module tb_alu_serial_ctrl;

  localparam int WIDTH = 16;
  localparam int LAT   = WIDTH + 1;  // edges from accept edge to done edge

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry_out;
  logic             overflow;

  int checks;
  int errors;

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .alu_ctl   (alu_ctl),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .zero      (zero),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [3:0]       ctl;
    logic [WIDTH-1:0] exp_res;
    logic             exp_zero;
    logic             exp_cout;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present an operation and hold start for exactly one edge; returns #1 after that edge.
  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic [3:0] tc);
    @(negedge clk);
    a = ta; b = tb_v; alu_ctl = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen; returns the bound value if it never comes.
  task automatic wait_done(output int edges);
    edges = 0;
    while (edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (done) break;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    start_op(v.va, v.vb, v.ctl);
    chk({v.name, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(n);
    chk({v.name, "_latency"}, n, LAT);
    chk({v.name, "_result"}, {16'd0, result}, {16'd0, v.exp_res});
    chk({v.name, "_zero"}, {31'd0, zero}, {31'd0, v.exp_zero});
    chk({v.name, "_cout"}, {31'd0, carry_out}, {31'd0, v.exp_cout});
    chk({v.name, "_ovf"}, {31'd0, overflow}, {31'd0, v.exp_ovf});
    chk({v.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk({v.name, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;

    //            name        a        b        ctl      res      z     cout  ovf
    vecs[0]  = '{"add_ovf",  16'h7FFF, 16'h0001, 4'b0010, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{"sub_eq",   16'h0005, 16'h0005, 4'b0110, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{"slt_ovf",  16'h8000, 16'h7FFF, 4'b0111, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"slt_neg",  16'h0001, 16'hFFFF, 4'b0111, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{"nor",      16'h0F0F, 16'h00FF, 4'b1100, 16'hF000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"and",      16'hF0F0, 16'hFF00, 4'b0000, 16'hF000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"or",       16'h1234, 16'h4321, 4'b0001, 16'h5335, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"sub_neg",  16'h0003, 16'h0005, 4'b0110, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"sub_ovf",  16'h8000, 16'h0001, 4'b0110, 16'h7FFF, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{"and_zero", 16'h00FF, 16'hFF00, 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{"nota_and", 16'h00FF, 16'h0FF0, 4'b1000, 16'h0F00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{"slt_pos",  16'h0002, 16'h0009, 4'b0111, 16'h0001, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; alu_ctl = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_done",   {31'd0, done}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_flags",  {29'd0, zero, carry_out, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // A start pulse mid-operation must be ignored.
    start_op(16'h0003, 16'h0004, 4'b0010);
    repeat (4) begin @(posedge clk); #1; end
    a = 16'hFFFF; b = 16'hFFFF; alu_ctl = 4'b0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'hAAAA; b = 16'h5555;  // operand changes while busy must not matter
    wait_done(n);
    chk("ign_latency", n + 5, LAT);
    chk("ign_result", {16'd0, result}, 32'h7);

    // start held in the done cycle is accepted back-to-back.
    a = 16'hF0F0; b = 16'hFF00; alu_ctl = 4'b0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_done_low", {31'd0, done}, 32'd0);
    wait_done(n);
    chk("b2b_latency", n, LAT);
    chk("b2b_result", {16'd0, result}, 32'hF000);

    // Reset mid-ADD discards the operation.
    @(posedge clk); #1;
    start_op(16'h0001, 16'h0002, 4'b0010);
    repeat (7) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_result", {16'd0, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(n);
    chk("rst_mid_no_done", {31'd0, done}, 32'd0);

    run_vec('{"add_wrap", 16'hFFFF, 16'h0001, 4'b0010, 16'h0000, 1'b1, 1'b1, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
